// File: rtl/comp_vec_gen.sv
// comp_vec_gen
// Stimulus source for the 4-bit magnitude comparator and its checker.
// Emits operand pairs A/B with the expected result code S3 over a
// valid/ready handshake. Two modes are available: an exhaustive sweep of
// all 256 pairs, or NUM_VEC pairs drawn from an 8-bit Fibonacci LFSR.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begins a run when seen high in IDLE
//   mode       0 = exhaustive sweep, 1 = LFSR run (captured with start)
//   out_valid  A/B/S3/last carry a vector
//   out_ready  consumer accepts the current vector
//   A, B       operands (A = src[7:4], B = src[3:0])
//   S3         expected result: 01 A>B, 10 B>A, 00 equal
//   last       current vector is the final one of the run
//   busy       run in progress
//   done       one-cycle pulse after the final handshake
module comp_vec_gen #(
    parameter int          NUM_VEC = 16,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [1:0] S3,
    output logic       last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // An all-zero LFSR state would lock up, so a zero seed is remapped.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [8:0] LAST_EXH  = 9'd255;
    localparam logic [8:0] LAST_LFSR = 9'(NUM_VEC - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  src_q;
    logic [8:0]  cnt_q;
    logic        mode_q;
    logic        run;
    logic        xfer;
    logic        is_last;

    function automatic logic [1:0] cmp_code(input logic [3:0] a, input logic [3:0] b);
        if (a > b)
            return 2'b01;
        else if (b > a)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign run     = (state_q == RUN);
    assign xfer    = run && out_ready;
    assign is_last = (cnt_q == (mode_q ? LAST_LFSR : LAST_EXH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (xfer && is_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= 8'h00;
            cnt_q   <= 9'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                mode_q <= mode;
                cnt_q  <= 9'd0;
                src_q  <= mode ? SEED_EFF : 8'h00;
            end else if (xfer) begin
                cnt_q <= cnt_q + 9'd1;
                src_q <= mode_q ? lfsr_next(src_q) : src_q + 8'd1;
            end
        end
    end

    // Operands are forced to zero outside RUN so idle outputs read as reset values.
    assign out_valid = run;
    assign busy      = run;
    assign done      = (state_q == DONE);
    assign A         = run ? src_q[7:4] : 4'h0;
    assign B         = run ? src_q[3:0] : 4'h0;
    assign S3        = cmp_code(A, B);
    assign last      = run && is_last;

endmodule

// File: tb/tb_comp_vec_gen.sv
module tb_comp_vec_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic mode = 1'b0;
    logic ready = 1'b1;
    logic sel = 1'b0;

    logic       v0, l0, bz0, d0, v1, l1, bz1, d1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] s0, s1;

    logic       o_valid, o_last, o_busy, o_done;
    logic [3:0] o_a, o_b;
    logic [1:0] o_s3;

    int total = 0;
    int bad = 0;
    logic [10:0] q[$];
    logic [10:0] got[0:255];
    int ntx;

    always #5 clk = ~clk;

    comp_vec_gen dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode),
        .out_valid(v0), .out_ready(ready), .A(a0), .B(b0), .S3(s0),
        .last(l0), .busy(bz0), .done(d0)
    );

    comp_vec_gen #(.NUM_VEC(1), .SEED(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode),
        .out_valid(v1), .out_ready(ready), .A(a1), .B(b1), .S3(s1),
        .last(l1), .busy(bz1), .done(d1)
    );

    always_comb begin
        o_valid = sel ? v1  : v0;
        o_a     = sel ? a1  : a0;
        o_b     = sel ? b1  : b0;
        o_s3    = sel ? s1  : s0;
        o_last  = sel ? l1  : l0;
        o_busy  = sel ? bz1 : bz0;
        o_done  = sel ? d1  : d0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] pack(input logic [3:0] a, input logic [3:0] b, input logic l);
        logic [1:0] s;
        s = (a > b) ? 2'b01 : ((a < b) ? 2'b10 : 2'b00);
        return {a, b, s, l};
    endfunction

    task automatic push_exh();
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            s = i[7:0];
            q.push_back(pack(s[7:4], s[3:0], i == 255));
        end
    endtask

    task automatic push_lfsr(input logic [7:0] seed, input int n);
        logic [7:0] s;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < n; i++) begin
            q.push_back(pack(s[7:4], s[3:0], i == n - 1));
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_vec"},   {o_a, o_b, o_s3, o_last}, 0);
    endtask

    // Pulse start for one cycle; returns at the negedge of the first RUN cycle.
    task automatic kick(input logic m);
        @(negedge clk);
        mode = m;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Consume vectors from the current negedge until last; returns in the DONE cycle.
    task automatic collect(input int stall_at, input int stall_len, output int n);
        int idx = 0;
        int stalled = 0;
        int gaps = 0;
        int cyc = 0;
        bit fin = 0;
        logic [10:0] cur, held, exp;
        held = '0;
        while (!fin && cyc < 2000) begin
            cur = {o_a, o_b, o_s3, o_last};
            if (!o_valid) begin
                gaps++;
            end else if (idx == stall_at && stalled < stall_len) begin
                if (stalled > 0) chk("stall_hold", cur, held);
                held = cur;
                ready = 1'b0;
                stalled++;
            end else begin
                ready = 1'b1;
                exp = (q.size() > 0) ? q.pop_front() : 11'bx;
                chk("sb_vec", cur, exp);
                if (idx < 256) got[idx] = cur;
                idx++;
                if (cur[0]) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        ready = 1'b1;
        chk("no_timeout", fin, 1);
        chk("no_gaps", gaps, 0);
        chk("sb_drained", q.size(), 0);
        chk("done_pulse", o_done, 1);
        chk("done_valid", o_valid, 0);
        chk("done_busy", o_busy, 0);
        n = idx;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Exhaustive sweep; mode toggled mid-run must not matter
        kick(1'b0);
        chk("lat_valid", o_valid, 1);
        chk("lat_busy", o_busy, 1);
        mode = 1'b1;
        push_exh();
        collect(-1, 0, ntx);
        chk("exh_count", ntx, 256);
        chk("exh_v0",   got[0],   {4'h0, 4'h0, 2'b00, 1'b0});
        chk("exh_v1",   got[1],   {4'h0, 4'h1, 2'b10, 1'b0});
        chk("exh_v16",  got[16],  {4'h1, 4'h0, 2'b01, 1'b0});
        chk("exh_v255", got[255], {4'hF, 4'hF, 2'b00, 1'b1});
        @(negedge clk);
        check_idle("exh_after_done");

        // LFSR run with default seed
        kick(1'b1);
        mode = 1'b0;
        push_lfsr(8'hA5, 16);
        collect(-1, 0, ntx);
        chk("lfsr_count", ntx, 16);
        chk("lfsr_v0", got[0], {4'hA, 4'h5, 2'b01, 1'b0});
        chk("lfsr_v1", got[1], {4'h4, 4'hA, 2'b10, 1'b0});
        chk("lfsr_last15", got[15][0], 1);
        chk("lfsr_last14", got[14][0], 0);
        @(negedge clk);

        // Backpressure at vector 5
        kick(1'b0);
        push_exh();
        collect(5, 3, ntx);
        chk("bp_count", ntx, 256);
        chk("bp_v5", got[5], {4'h0, 4'h5, 2'b10, 1'b0});
        chk("bp_v6", got[6], {4'h0, 4'h6, 2'b10, 1'b0});
        @(negedge clk);

        // start held high through the run and DONE
        mode = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        push_exh();
        collect(-1, 0, ntx);
        chk("hold_count", ntx, 256);
        @(negedge clk);
        check_idle("hold_idle");
        @(negedge clk);
        start0 = 1'b0;
        chk("restart_valid", o_valid, 1);
        push_exh();
        collect(-1, 0, ntx);
        chk("restart_count", ntx, 256);
        chk("restart_v0", got[0], {4'h0, 4'h0, 2'b00, 1'b0});
        @(negedge clk);

        // Asynchronous reset mid-run at vector 100
        kick(1'b0);
        ntx = 0;
        for (int c = 0; c < 300 && ntx < 100; c++) begin
            if (o_valid && ready) ntx++;
            @(negedge clk);
        end
        chk("rst_at_v100", {o_valid, o_a, o_b}, {1'b1, 4'h6, 4'h4});
        rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", o_done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_release");
        kick(1'b0);
        push_exh();
        collect(-1, 0, ntx);
        chk("rst_rerun_count", ntx, 256);
        chk("rst_rerun_v0", got[0], {4'h0, 4'h0, 2'b00, 1'b0});
        @(negedge clk);

        // Zero seed, single vector
        sel = 1'b1;
        #1;
        check_idle("single_idle");
        kick(1'b1);
        push_lfsr(8'h00, 1);
        collect(-1, 0, ntx);
        chk("single_count", ntx, 1);
        chk("single_v0", got[0], {4'h0, 4'h1, 2'b10, 1'b1});
        @(negedge clk);
        check_idle("single_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comp_vec_gen.md
# comp_vec_gen

Hardware stimulus source for the 4-bit magnitude comparator. It emits operand pairs A/B together with the expected 2-bit result code S3, in the same encoding the comparator checker consumes. It drives the comparator and checker through a valid/ready handshake, replacing file-based vectors in on-chip self-test. It generates vectors in one of two selectable modes: an exhaustive sweep or an LFSR-based pseudo-random run.

## Interface
- NUM_VEC, 16, number of vectors produced in LFSR mode; legal range 1..256.
- SEED, 8'hA5, LFSR seed; a value of 8'h00 is replaced internally by 8'h01.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  starts a run when sampled high in IDLE.
- mode  input  1  0 = exhaustive (256 pairs), 1 = LFSR (NUM_VEC pairs); sampled with start.
- out_valid  output  1  A/B/S3/last are valid.
- out_ready  input  1  consumer accepts the vector.
- A  output  4  operand A.
- B  output  4  operand B.
- S3  output  2  expected result: 2'b01 A>B, 2'b10 B>A, 2'b00 A==B; 2'b11 never driven.
- last  output  1  current vector is the final one of the run.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final handshake.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches mode, clears the 9-bit vector counter, and loads the 8-bit source register.
  - Exhaustive mode loads 8'h00.
  - LFSR mode loads SEED, or 8'h01 if SEED is zero.
  - The FSM then goes to RUN.
- RUN: A = src[7:4], B = src[3:0]. S3 is computed combinationally from the registered A/B; all outputs are glitch-free, registered-source.
- Handshake: a transfer occurs when out_valid && out_ready. On a transfer:
  - the counter increments;
  - the source advances:
    - exhaustive: src+1;
    - LFSR: src <= {src[6:0], src[7]^src[5]^src[4]^src[3]}.
- Total vectors per run: 256 in exhaustive mode, NUM_VEC in LFSR mode. last = (counter == total-1).
- A transfer with last=1 moves the FSM to DONE. DONE lasts exactly one cycle, then the FSM returns to IDLE.
- Stall: while out_valid && !out_ready, A, B, S3 and last hold stable.
- start is ignored in RUN and DONE. mode changes after start have no effect on the current run.
- LFSR sequences may repeat pairs; no uniqueness is guaranteed.

## Timing
- Reset (asynchronous, any state, including mid-run): FSM=IDLE, out_valid=0, A=0, B=0, S3=2'b00, last=0, busy=0, done=0, counter=0. Any run in progress is abandoned; no done pulse is generated.
- Latency: start sampled at edge N → out_valid=1 and busy=1 after edge N, so the first vector is visible in cycle N+1.
- Throughput: with out_ready held high, one vector per cycle with no bubbles. out_valid stays high continuously through the run.
- Final transfer at edge M → out_valid=0, busy=0, done=1 in cycle M+1 (DONE). done=0 and FSM=IDLE after edge M+1.
- Earliest restart: start sampled high at edge M+2, i.e. the first IDLE cycle.
- NUM_VEC=1: the first vector has last=1 and the run lasts one transfer.
- out_ready is allowed high while out_valid=0; this has no effect.

## Test plan
- Exhaustive, out_ready=1, start pulsed once:
  - vector 0: A=0, B=0, S3=00;
  - vector 1: A=0, B=1, S3=10;
  - vector 16: A=1, B=0, S3=01;
  - vector 255: A=F, B=F, S3=00, last=1;
  - exactly 256 transfers, then done=1 for one cycle.
- LFSR, SEED=8'hA5, NUM_VEC=16:
  - vector 0: A=A, B=5, S3=01;
  - vector 1: src=8'h4A, A=4, B=A, S3=10;
  - 16 transfers with last on the 16th.
- Backpressure: exhaustive run, out_ready low for 3 cycles while out_valid=1 at vector 5 (A=0, B=5) → outputs hold; counter advances only on the transfer; total still 256.
- start held high through the whole run and the DONE cycle → no restart before the first IDLE cycle, then a new run begins with vector 0.
- rst_n asserted at exhaustive vector 100 → all outputs zero immediately, no done pulse; after release, start produces vector 0 again.
- SEED=8'h00, NUM_VEC=1 → single vector A=0, B=1, S3=10, last=1, then done.
